ahb_slv_mem: RTL

AHB slave with an internal register-file memory. It is the responder counterpart to the team's AHB master and is the default target for that master in block-level and system benches. It decodes the address and data phases, inserts a configurable number of wait states, and performs byte/halfword/word reads and writes. Illegal accesses get the two-cycle ERROR response.

---
 rtl/ahb_slv_mem.sv | 94 +++++++++
 1 files changed

// File: rtl/ahb_slv_mem.sv
// ahb_slv_mem: AHB slave backed by a register-file memory, with configurable wait states
// and the two-cycle ERROR response for out-of-range, misaligned or oversized transfers.
module ahb_slv_mem #(
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic        HCLK,
  input  logic        HRST_N,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic [1:0]  HRESP
);
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;
  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [1:0]            off_q, off_d;
  logic [2:0]            size_q, size_d;
  logic                  write_q, write_d;
  logic [31:0]           mem [2**ADDR_WIDTH];
  logic                  open, acc, ill, we;
  logic [3:0]            be;
  logic                  unused_bits;
  assign unused_bits = ^{HTRANS[0], HBURST};
  // A new address phase may only be taken while this slave drives HREADYOUT high.
  assign open = (state_q == S_IDLE) || (state_q == S_DATA) || (state_q == S_ERR2);
  assign acc  = open & HSEL & HREADY & HTRANS[1];
  assign ill  = (HADDR[31:ADDR_WIDTH+2] != '0) || (HSIZE == 3'b001 && HADDR[0]) ||
                (HSIZE == 3'b010 && HADDR[1:0] != 2'b00) || (HSIZE > 3'b010);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    off_d   = off_q;
    size_d  = size_q;
    write_d = write_q;
    case (state_q)
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_DATA;
      end
      S_ERR1:  state_d = S_ERR2;
      default: state_d = S_IDLE;
    endcase
    if (acc) begin
      idx_d   = HADDR[ADDR_WIDTH+1:2];
      off_d   = HADDR[1:0];
      size_d  = HSIZE;
      write_d = HWRITE;
      if (ill) state_d = S_ERR1;
      else begin
        state_d = (WAIT_STATES > 0) ? S_WAIT : S_DATA;
        cnt_d   = 4'(WAIT_STATES);
      end
    end
  end
  always_ff @(posedge HCLK or negedge HRST_N) begin
    if (!HRST_N) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      off_q   <= '0;
      size_q  <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      off_q   <= off_d;
      size_q  <= size_d;
      write_q <= write_d;
    end
  end
  // Only legal transfers reach S_DATA, so registered size/offset are already aligned.
  assign we = (state_q == S_DATA) && write_q;
  assign be = (size_q == 3'b000) ? 4'b0001 << off_q :
              (size_q == 3'b001) ? 4'b0011 << off_q : 4'b1111;
  always_ff @(posedge HCLK) begin
    if (we)
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
  end
  assign HRDATA    = (state_q == S_DATA && !write_q) ? mem[idx_q] : '0;
  assign HREADYOUT = !((state_q == S_WAIT) || (state_q == S_ERR1));
  assign HRESP     = ((state_q == S_ERR1) || (state_q == S_ERR2)) ? 2'b01 : 2'b00;
endmodule
